// File: rtl/stereo_sample_queue_if.sv
// Sample-in / replay-out bundle of stereo_sample_queue.
// master = sample producer and stream consumer side, slave = the queue itself.
interface stereo_sample_queue_if;
    logic        new_smpl;
    logic [15:0] lft_in;
    logic [15:0] rght_in;
    logic        sequencing;
    logic [15:0] lft_out;
    logic [15:0] rght_out;
    logic        full;

    modport master (
        output new_smpl, lft_in, rght_in,
        input  sequencing, lft_out, rght_out, full
    );

    modport slave (
        input  new_smpl, lft_in, rght_in,
        output sequencing, lft_out, rght_out, full
    );
endinterface

// File: rtl/stereo_sample_queue.sv
// Stereo circular sample buffer; replays the newest WINDOW samples, oldest first, per pass.
// Optional SEQ_ZERO_FILL_EN: replay from the first write, unwritten window slots read as 0.
//
// state | meaning
// IDLE  | no pass running; waiting for a write (or pending start) with the start condition met
// PRIME | read of the window's oldest sample issued; sequencing still low
// READ  | sample k on the outputs, read of sample k+1 issued; rd_cnt = samples left after k
module stereo_sample_queue #(
    parameter int WINDOW = 1021,
    parameter int AW     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stereo_sample_queue_if.slave sq
);
    localparam int              DEPTH  = 1 << AW;
    localparam int              CW     = $clog2(WINDOW + 1);
    localparam logic [AW-1:0]   BACK   = AW'(WINDOW - 1);
    localparam logic [CW-1:0]   WIN_C  = CW'(WINDOW);
    localparam logic [CW-1:0]   LAST_C = CW'(WINDOW - 1);

    typedef enum logic [1:0] {IDLE, PRIME, READ} state_t;

    state_t        state;
    logic [15:0]   mem_l [DEPTH];
    logic [15:0]   mem_r [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] newest;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] rd_cnt;
    logic          pend;
    logic          start_req;
    logic          start_ok;
    logic          launch;
    logic          rd_zero;
`ifdef SEQ_ZERO_FILL_EN
    logic [CW-1:0] valid_from;
    logic [CW-1:0] rd_idx;
`endif

    always_ff @(posedge clk) begin
        if (sq.new_smpl) begin
            mem_l[wptr] <= sq.lft_in;
            mem_r[wptr] <= sq.rght_in;
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (sq.new_smpl && cnt != WIN_C) cnt_nxt = cnt + CW'(1);
        // Newest sample is the one being written now, else the last one written.
        newest    = sq.new_smpl ? wptr : wptr - AW'(1);
        start_req = sq.new_smpl | pend;
`ifdef SEQ_ZERO_FILL_EN
        start_ok = (cnt_nxt != '0);
        rd_idx   = (state == PRIME) ? '0 : WIN_C - rd_cnt;
        rd_zero  = (rd_idx < valid_from);
`else
        start_ok = (cnt_nxt == WIN_C);
        rd_zero  = 1'b0;
`endif
        launch = start_req && start_ok &&
                 ((state == IDLE) || (state == READ && rd_cnt == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wptr          <= '0;
            rptr          <= '0;
            cnt           <= '0;
            rd_cnt        <= '0;
            pend          <= 1'b0;
            sq.full       <= 1'b0;
            sq.sequencing <= 1'b0;
            sq.lft_out    <= '0;
            sq.rght_out   <= '0;
`ifdef SEQ_ZERO_FILL_EN
            valid_from    <= '0;
`endif
        end else begin
            cnt     <= cnt_nxt;
            sq.full <= (cnt_nxt == WIN_C);
            if (sq.new_smpl) begin
                wptr <= wptr + AW'(1);
                if (state != IDLE) pend <= 1'b1;
            end

            case (state)
                IDLE: ;
                PRIME: begin
                    state         <= READ;
                    sq.sequencing <= 1'b1;
                    sq.lft_out    <= rd_zero ? '0 : mem_l[rptr];
                    sq.rght_out   <= rd_zero ? '0 : mem_r[rptr];
                    rptr          <= rptr + AW'(1);
                end
                READ: begin
                    if (rd_cnt == '0) begin
                        state         <= IDLE;
                        sq.sequencing <= 1'b0;
                        sq.lft_out    <= '0;
                        sq.rght_out   <= '0;
                    end else begin
                        sq.lft_out  <= rd_zero ? '0 : mem_l[rptr];
                        sq.rght_out <= rd_zero ? '0 : mem_r[rptr];
                        rptr        <= rptr + AW'(1);
                        rd_cnt      <= rd_cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Start of a pass overrides the case above, including the pend set.
            if (launch) begin
                state  <= PRIME;
                rptr   <= newest - BACK;
                rd_cnt <= LAST_C;
                pend   <= 1'b0;
`ifdef SEQ_ZERO_FILL_EN
                valid_from <= WIN_C - cnt_nxt;
`endif
            end
        end
    end
endmodule
